// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request channel; every accepted
// access completes with a one-cycle response after a fixed number of wait cycles.
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem [DEPTH];

  logic          accept, enter_resp, fault;
  logic          acc_write;
  logic [31:0]   acc_addr, acc_wdata;
  logic [AW-1:0] acc_idx;

  assign accept     = req_valid && req_ready;
  assign enter_resp = (state_nxt == RESP);

  // With LATENCY = 0 the RESP edge is the accept edge itself, so the live request
  // is used instead of the (not yet loaded) capture registers.
  assign acc_write = (state == IDLE) ? req_write : wr_q;
  assign acc_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;
  assign acc_idx   = acc_addr[AW+1:2];
  assign fault     = (|acc_addr[1:0]) || (|acc_addr[31:AW+2]);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      cnt     <= (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response data is loaded only on the edge entering RESP and zero otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (enter_resp) begin
      resp_err   <= fault;
      resp_rdata <= (!acc_write && !fault) ? mem[acc_idx] : 32'd0;
    end else begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end
  end

  // NOTE: storage has no reset so its contents survive reset and it can map to RAM.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_write && !fault) mem[acc_idx] <= acc_wdata;
  end

endmodule
